tlb_plru_array: RTL and testbench

- Sequential, parametrised tree-PLRU replacement-state store for a set-associative TLB level (L2 TLB or a larger L1).
- Holds one PLRU tree per set and applies hit and refill updates.
- Returns a registered victim way per request, preferring invalid ways.
- Provides a set-walking flush for sfence; the walk blocks requests while it runs.

---
 rtl/tlb_plru_array.sv | 137 +++++++++++++
 tb/tb_tlb_plru_array.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_plru_array.sv
// Tree-PLRU replacement state for a set-associative TLB: hit/refill touches,
// registered victim selection preferring invalid ways, and a set-walking flush.
module tlb_plru_array #(
    parameter int WAYS     = 8,
    parameter int SETS     = 16,
    parameter int SET_BITS = (SETS > 1) ? $clog2(SETS) : 1,
    parameter int WAY_BITS = $clog2(WAYS)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                hit_valid,
    input  logic [SET_BITS-1:0] hit_set,
    input  logic [WAYS-1:0]     hit_ways,
    input  logic                fill_valid,
    input  logic [SET_BITS-1:0] fill_set,
    input  logic [WAY_BITS-1:0] fill_way,
    input  logic                repl_req_valid,
    output logic                repl_req_ready,
    input  logic [SET_BITS-1:0] repl_set,
    input  logic [WAYS-1:0]     repl_valid_mask,
    output logic                repl_resp_valid,
    output logic [WAY_BITS-1:0] repl_resp_way,
    input  logic                flush_req,
    output logic                busy
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SET_BITS-1:0] r_flush_cnt;
    logic [WAYS-1:0]     r_tree [SETS];
    logic                r_resp_valid;
    logic [WAY_BITS-1:0] r_resp_way;

    logic                w_hit_en;
    logic [WAY_BITS-1:0] w_hit_way;
    logic [WAY_BITS-1:0] w_victim;
    logic                w_req_fire;
    logic                w_flush_last;

    // Walk root to leaf; n tracks the heap index, each node points away from the touched way.
    function automatic logic [WAYS-1:0] f_touch(input logic [WAYS-1:0] tree,
                                                input logic [WAY_BITS-1:0] way);
        logic [WAYS-1:0]     t;
        logic [WAY_BITS:0]   n;
        logic [WAY_BITS-1:0] w;
        t = tree;
        n = 1;
        w = way;
        for (int l = 0; l < WAY_BITS; l++) begin
            t[n[WAY_BITS-1:0]] = ~w[WAY_BITS-1];
            n = {n[WAY_BITS-1:0], w[WAY_BITS-1]};
            w = w << 1;
        end
        return t;
    endfunction

    function automatic logic [WAY_BITS-1:0] f_victim(input logic [WAYS-1:0] tree,
                                                     input logic [WAYS-1:0] mask);
        logic [WAY_BITS:0]   n;
        logic [WAY_BITS-1:0] v;
        n = 1;
        for (int l = 0; l < WAY_BITS; l++) begin
            n = {n[WAY_BITS-1:0], tree[n[WAY_BITS-1:0]]};
        end
        v = n[WAY_BITS-1:0];
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!mask[i]) v = WAY_BITS'(i);
        end
        return v;
    endfunction

    always_comb begin
        w_hit_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (hit_ways[i]) w_hit_way = WAY_BITS'(i);
        end
    end

    assign w_hit_en     = hit_valid && (hit_ways != '0);
    assign w_victim     = f_victim(r_tree[repl_set], repl_valid_mask);
    assign w_req_fire   = repl_req_valid && repl_req_ready;
    assign w_flush_last = (r_flush_cnt == SET_BITS'(SETS - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (flush_req) w_state_nxt = S_FLUSH;
            S_FLUSH: if (w_flush_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= (r_state == S_FLUSH) ? r_flush_cnt + 1'b1 : '0;
        end
    end

    // Fill is applied on top of the hit when both land on the same set.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int s = 0; s < SETS; s++) r_tree[s] <= '0;
        end else if (r_state == S_FLUSH) begin
            r_tree[r_flush_cnt] <= '0;
        end else if (w_hit_en && fill_valid && (hit_set == fill_set)) begin
            r_tree[fill_set] <= f_touch(f_touch(r_tree[fill_set], w_hit_way), fill_way);
        end else begin
            if (w_hit_en) r_tree[hit_set] <= f_touch(r_tree[hit_set], w_hit_way);
            if (fill_valid) r_tree[fill_set] <= f_touch(r_tree[fill_set], fill_way);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_resp_valid <= 1'b0;
            r_resp_way   <= '0;
        end else begin
            r_resp_valid <= w_req_fire;
            if (w_req_fire) r_resp_way <= w_victim;
        end
    end

    assign repl_req_ready  = (r_state == S_IDLE);
    assign busy            = (r_state == S_FLUSH);
    assign repl_resp_valid = r_resp_valid;
    assign repl_resp_way   = r_resp_way;

endmodule

// File: tb/tb_tlb_plru_array.sv
// Randomised and directed bench for tlb_plru_array: a heap-indexed PLRU model
// feeds an expected-victim queue that a negedge monitor drains.
module tb_tlb_plru_array;

    localparam int WAYS = 8;
    localparam int SETS = 16;
    localparam int SB   = 4;
    localparam int WB   = 3;

    logic          clk;
    logic          reset_n;
    logic          hit_valid;
    logic [SB-1:0] hit_set;
    logic [WAYS-1:0] hit_ways;
    logic          fill_valid;
    logic [SB-1:0] fill_set;
    logic [WB-1:0] fill_way;
    logic          repl_req_valid;
    logic          repl_req_ready;
    logic [SB-1:0] repl_set;
    logic [WAYS-1:0] repl_valid_mask;
    logic          repl_resp_valid;
    logic [WB-1:0] repl_resp_way;
    logic          flush_req;
    logic          busy;

    tlb_plru_array #(.WAYS(WAYS), .SETS(SETS)) dut (
        .clk(clk), .reset_n(reset_n),
        .hit_valid(hit_valid), .hit_set(hit_set), .hit_ways(hit_ways),
        .fill_valid(fill_valid), .fill_set(fill_set), .fill_way(fill_way),
        .repl_req_valid(repl_req_valid), .repl_req_ready(repl_req_ready),
        .repl_set(repl_set), .repl_valid_mask(repl_valid_mask),
        .repl_resp_valid(repl_resp_valid), .repl_resp_way(repl_resp_way),
        .flush_req(flush_req), .busy(busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [WB-1:0] exp_q[$];
    logic [WB-1:0] m_last;

    // reference model: node[s][n] for heap node n, leaves WAYS+way
    int m_node [SETS][WAYS];
    bit m_busy;
    int m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_clear_set(int s);
        for (int n = 0; n < WAYS; n++) m_node[s][n] = 0;
    endfunction

    function automatic void m_touch(int s, int way);
        int c;
        c = way + WAYS;
        while (c > 1) begin
            m_node[s][c / 2] = (c % 2 == 0) ? 1 : 0;
            c = c / 2;
        end
    endfunction

    function automatic int m_victim(int s, logic [WAYS-1:0] mask);
        int n;
        for (int i = 0; i < WAYS; i++) if (!mask[i]) return i;
        n = 1;
        while (n < WAYS) n = 2 * n + m_node[s][n];
        return n - WAYS;
    endfunction

    function automatic int lowest_bit(logic [WAYS-1:0] v);
        for (int i = 0; i < WAYS; i++) if (v[i]) return i;
        return -1;
    endfunction

    // driver: inputs are already set; update the model, take one edge, idle inputs
    task automatic tick();
        if (!reset_n) begin
            for (int s = 0; s < SETS; s++) m_clear_set(s);
            m_busy = 0;
            m_cnt  = 0;
            exp_q.delete();
            m_last = '0;
        end else begin
            if (repl_req_valid && !m_busy) exp_q.push_back(WB'(m_victim(int'(repl_set), repl_valid_mask)));
            if (m_busy) begin
                m_clear_set(m_cnt);
                m_cnt++;
                if (m_cnt == SETS) m_busy = 0;
            end else begin
                if (hit_valid && hit_ways != '0) m_touch(int'(hit_set), lowest_bit(hit_ways));
                if (fill_valid) m_touch(int'(fill_set), int'(fill_way));
                if (flush_req) begin
                    m_busy = 1;
                    m_cnt  = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1; hit_valid = 1'b0; fill_valid = 1'b0;
        repl_req_valid = 1'b0; flush_req = 1'b0;
        check("busy", busy, m_busy);
        check("ready", repl_req_ready, !m_busy);
    endtask

    task automatic do_hit(input int s, input logic [WAYS-1:0] w);
        hit_valid = 1'b1; hit_set = SB'(s); hit_ways = w;
        tick();
    endtask

    task automatic do_req(input int s, input logic [WAYS-1:0] mask);
        repl_req_valid = 1'b1; repl_set = SB'(s); repl_valid_mask = mask;
        tick();
    endtask

    task automatic req_all_sets();
        for (int s = 0; s < SETS; s++) do_req(s, 8'hFF);
    endtask

    task automatic rand_inputs(input bit allow_flush);
        hit_valid       = 1'($urandom_range(0, 1));
        hit_set         = SB'($urandom_range(0, SETS - 1));
        hit_ways        = ($urandom_range(0, 4) == 0) ? '0 : WAYS'($urandom);
        fill_valid      = 1'($urandom_range(0, 2) == 0);
        fill_set        = ($urandom_range(0, 3) == 0) ? hit_set : SB'($urandom_range(0, SETS - 1));
        fill_way        = WB'($urandom);
        repl_req_valid  = 1'($urandom_range(0, 1));
        repl_set        = SB'($urandom_range(0, SETS - 1));
        repl_valid_mask = ($urandom_range(0, 2) == 0) ? WAYS'($urandom) : 8'hFF;
        flush_req       = allow_flush && ($urandom_range(0, 199) == 0);
    endtask

    // monitor: every presented response pops one expectation; otherwise the way must hold
    always @(negedge clk) begin
        if (reset_n) begin
            if (repl_resp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL resp_unexpected: got way %0d with no request outstanding at %0t",
                             repl_resp_way, $time);
                end else begin
                    m_last = exp_q.pop_front();
                    check("resp_way", repl_resp_way, m_last);
                end
            end else begin
                check("resp_hold", repl_resp_way, m_last);
            end
        end
    end

    initial begin
        reset_n = 1'b0; hit_valid = 1'b0; hit_set = '0; hit_ways = '0;
        fill_valid = 1'b0; fill_set = '0; fill_way = '0;
        repl_req_valid = 1'b0; repl_set = '0; repl_valid_mask = '1; flush_req = 1'b0;
        m_last = '0;
        tick();
        reset_n = 1'b0;
        tick();
        check("rst_resp_valid", repl_resp_valid, 0);
        check("rst_resp_way", repl_resp_way, 0);

        // basic victim on a fresh set, then one-hot training
        do_req(3, 8'hFF);
        tick();
        do_hit(3, 8'h01);
        do_req(3, 8'hFF);
        do_req(5, 8'hFF);
        for (int w = 0; w < WAYS; w++) do_hit(3, WAYS'(1) << w);
        do_req(3, 8'hFF);
        do_req(3, 8'hFB);
        do_hit(4, 8'b0110_1000);
        do_req(4, 8'hFF);
        do_hit(4, 8'h00);
        do_req(4, 8'hFF);

        // hit and fill on the same set in one cycle
        hit_valid = 1'b1; hit_set = 4'd2; hit_ways = 8'h02;
        fill_valid = 1'b1; fill_set = 4'd2; fill_way = 3'd6;
        tick();
        do_req(2, 8'hFF);
        hit_valid = 1'b1; hit_set = 4'd7; hit_ways = 8'h80;
        fill_valid = 1'b1; fill_set = 4'd8; fill_way = 3'd3;
        tick();
        do_req(7, 8'hFF);
        do_req(8, 8'hFF);

        // full flush walk with traffic that must be dropped
        for (int s = 0; s < SETS; s++) do_hit(s, WAYS'(1) << (s % WAYS));
        repl_req_valid = 1'b1; repl_set = 4'd1; repl_valid_mask = 8'hFF;
        flush_req = 1'b1;
        tick();
        for (int c = 0; c < SETS; c++) begin
            rand_inputs(1'b1);
            tick();
        end
        tick();
        req_all_sets();

        // reset during the fifth flush cycle
        for (int s = 0; s < SETS; s++) do_hit(s, 8'h01);
        flush_req = 1'b1;
        tick();
        for (int c = 0; c < 4; c++) tick();
        reset_n = 1'b0;
        tick();
        check("midflush_resp_valid", repl_resp_valid, 0);
        req_all_sets();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rand_inputs(1'b1);
            tick();
        end
        for (int i = 0; i < 20; i++) tick();
        req_all_sets();
        tick();
        tick();
        check("exp_q_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
